// File: rtl/z80_sys_pkg.sv
// Shared types and constants for the Z80 system memory path and DMA arbiter.
package z80_sys_pkg;

   localparam int MEM_AW = 16;
   localparam int MEM_DW = 8;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      OWN,
      DRAIN,
      REL
   } arb_state_t;

endpackage

// File: rtl/z80_dma_addr_gen.sv
// DMA burst address / beat counter. The count is one bit wider than the
// length field so that a zero length can be loaded as 2^LEN_W beats.
module z80_dma_addr_gen
   import z80_sys_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              step,
   input  logic [MEM_AW-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [MEM_AW-1:0] addr,
   output logic              last
);

   logic [LEN_W:0] remain;

   // Load on burst start; each step advances the address (16-bit wrap) and consumes a beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr   <= '0;
         remain <= '0;
      end else if (load) begin
         addr   <= load_addr;
         remain <= (load_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, load_len};
      end else if (step) begin
         addr   <= addr + 1'b1;
         remain <= remain - 1'b1;
      end
   end

   assign last = (remain == {{LEN_W{1'b0}}, 1'b1});

endmodule

// File: rtl/z80_dma_bus_arbiter.sv
// Arbitrates the single system memory between the Z80 CPU and one DMA client
// using the BUSRQ_n/BUSAK_n handshake. The memory follows the CPU except while
// the controller owns the bus.
module z80_dma_bus_arbiter
   import z80_sys_pkg::*;
#(
   parameter int ACK_TIMEOUT = 64,
   parameter int LEN_W       = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              cpu_busrq_n,
   input  logic              cpu_busak_n,
   input  logic [MEM_AW-1:0] cpu_a,
   input  logic [MEM_DW-1:0] cpu_do,
   input  logic              cpu_mreq_n,
   input  logic              cpu_wr_n,
   output logic [MEM_AW-1:0] mem_a,
   output logic [MEM_DW-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [MEM_DW-1:0] mem_rdata,
   input  logic              dma_start,
   input  logic              dma_dir,
   input  logic [MEM_AW-1:0] dma_addr,
   input  logic [LEN_W-1:0]  dma_len,
   input  logic [MEM_DW-1:0] dma_wdata,
   input  logic              dma_wvalid,
   output logic              dma_wready,
   output logic [MEM_DW-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              dma_busy,
   output logic              dma_done,
   output logic              dma_err
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   arb_state_t        state, state_n;
   logic              dir;
   logic              err_flag;
   logic [TW-1:0]     tcnt;
   logic              ag_load, ag_step, ag_last;
   logic [MEM_AW-1:0] ag_addr;
   logic              beat;
   logic              own;

   z80_dma_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ag_load),
      .step      (ag_step),
      .load_addr (dma_addr),
      .load_len  (dma_len),
      .addr      (ag_addr),
      .last      (ag_last)
   );

   // State register plus registered handshake, status and read-return flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         dir         <= DIR_RD;
         err_flag    <= 1'b0;
         tcnt        <= '0;
         cpu_busrq_n <= 1'b1;
         dma_busy    <= 1'b0;
         dma_done    <= 1'b0;
         dma_err     <= 1'b0;
         dma_rvalid  <= 1'b0;
      end else begin
         state <= state_n;
         if (ag_load)
            dir <= dma_dir;
         if (ag_load)
            err_flag <= 1'b0;
         else if (state == REQ && state_n == REL)
            err_flag <= 1'b1;
         tcnt        <= (state == REQ) ? tcnt + 1'b1 : '0;
         cpu_busrq_n <= !(state_n inside {REQ, OWN, DRAIN});
         dma_busy    <= (state_n != IDLE);
         dma_done    <= (state == REL) && (state_n == IDLE) && !err_flag;
         dma_err     <= (state == REL) && (state_n == IDLE) && err_flag;
         // Synchronous memory: data for an address issued now arrives next cycle.
         dma_rvalid  <= (state == OWN) && (dir == DIR_RD);
      end
   end

   // Next-state and burst control; an acknowledge beats a simultaneous timeout.
   always_comb begin
      state_n    = state;
      ag_load    = 1'b0;
      ag_step    = 1'b0;
      dma_wready = 1'b0;
      beat       = 1'b0;
      case (state)
         IDLE: begin
            if (dma_start) begin
               ag_load = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (!cpu_busak_n)
               state_n = OWN;
            else if (tcnt == TW'(ACK_TIMEOUT - 1))
               state_n = REL;
         end
         OWN: begin
            if (dir == DIR_WR) begin
               dma_wready = 1'b1;
               if (dma_wvalid) begin
                  beat    = 1'b1;
                  ag_step = 1'b1;
                  if (ag_last)
                     state_n = REL;
               end
            end else begin
               ag_step = 1'b1;
               if (ag_last)
                  state_n = DRAIN;
            end
         end
         DRAIN: state_n = REL;
         REL: begin
            if (cpu_busak_n)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Memory mux: DMA only in OWN, where CPU strobes are masked off.
   always_comb begin
      own       = (state == OWN);
      mem_a     = own ? ag_addr : cpu_a;
      mem_wdata = own ? dma_wdata : cpu_do;
      mem_we    = own ? beat : (~cpu_mreq_n & ~cpu_wr_n);
      dma_rdata = dma_rvalid ? mem_rdata : '0;
   end

endmodule
